// File: rtl/ccip_vc_line_limiter_pkg.sv
// ccip_limiter_pkg: shared definitions for the CCI-P c0 per-VC line limiter.
//   MAX_REQ_LINES     largest line count a single c0 request can carry.
//   t_line_cnt        in-flight line counter type sized for the default budget.
//   cl_len_to_lines() converts the encoded cl_len field to a line count.
package ccip_limiter_pkg;

    localparam int MAX_REQ_LINES            = 4;
    localparam int DEFAULT_MAX_ACTIVE_LINES = 512;
    localparam int DEFAULT_CNT_W            = $clog2(DEFAULT_MAX_ACTIVE_LINES + 1);

    typedef logic [DEFAULT_CNT_W-1:0] t_line_cnt;

    // cl_len encodes lines minus one (0 = 1 line ... 3 = 4 lines).
    function automatic int unsigned cl_len_to_lines(input int unsigned cl_len);
        return cl_len + 32'd1;
    endfunction

endpackage

// File: rtl/ccip_vc_line_limiter_if.sv
// ccip_vc_line_limiter_if: one c0 read-request channel.
//   valid/ready handshake: a request transfers on a rising clock edge where
//   valid and ready are both high; while valid is high and the transfer has
//   not happened, the master holds vc and cl_len stable. ready may depend
//   combinationally on vc/cl_len.
//   master modport drives valid/vc/cl_len, slave modport drives ready.
interface ccip_vc_line_limiter_if #(
    parameter int VC_W     = 2,
    parameter int CL_LEN_W = 2
);
    logic                valid;
    logic                ready;
    logic [VC_W-1:0]     vc;
    logic [CL_LEN_W-1:0] cl_len;

    modport master (output valid, output vc, output cl_len, input ready);
    modport slave  (input valid, input vc, input cl_len, output ready);
endinterface

// File: rtl/ccip_vc_line_limiter_counter.sv
// ccip_vc_line_counter: in-flight line counter for one virtual channel.
//   inc_en/inc_lines  add inc_lines (request accepted on this VC).
//   dec_en            subtract one line (response returned on this VC).
//   count             current in-flight lines (registered).
//   blocked           registered: post-update count cannot absorb a
//                     worst-case request.
//   underflow         combinational: a decrement found nothing to remove.
module ccip_vc_line_counter
    import ccip_limiter_pkg::*;
#(
    parameter int CNT_W            = 10,
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int INC_W            = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_en,
    input  logic [INC_W-1:0] inc_lines,
    input  logic             dec_en,
    output logic [CNT_W-1:0] count,
    output logic             blocked,
    output logic             underflow
);

    logic [CNT_W-1:0] count_d, count_q;
    logic             blocked_d, blocked_q;
    logic [CNT_W:0]   sum;

    // Increment and decrement fold into one update so a same-cycle accept
    // and response never lose an event. A decrement only underflows when
    // nothing (including this cycle's increment) is in flight.
    always_comb begin
        sum       = {1'b0, count_q} + (inc_en ? (CNT_W+1)'(inc_lines) : '0);
        underflow = 1'b0;
        if (dec_en) begin
            if (sum == '0) begin
                underflow = 1'b1;
            end else begin
                sum = sum - (CNT_W+1)'(1);
            end
        end
        count_d   = sum[CNT_W-1:0];
        blocked_d = (int'(sum) + MAX_REQ_LINES) > MAX_ACTIVE_LINES;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            blocked_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            blocked_q <= blocked_d;
        end
    end

    assign count   = count_q;
    assign blocked = blocked_q;

endmodule

// File: rtl/ccip_vc_line_limiter.sv
// ccip_vc_line_limiter: per-VC in-flight line budget on the CCI-P c0 path.
//   clk, reset_n      clock, asynchronous active-low reset.
//   in_req (slave)    upstream requests; ready only when the output register
//                     is free and the VC budget can absorb cl_len+1 lines.
//   out_req (master)  one-entry registered request stage towards the shim.
//   rsp_valid/rsp_vc  one returned line per cycle, tagged with its VC.
//   vc_active_lines   per-VC in-flight counts, VC0 at the LSBs.
//   vc_blocked        per-VC: count + 4 exceeds the budget (registered).
//   underflow_err     sticky: response on an empty or out-of-range VC.
// Optional: define CCIP_VC_LINE_LIMITER_STATS_EN to add vc_stall_cycles,
//   per-VC saturating 32-bit counts of cycles stalled by the budget.
module ccip_vc_line_limiter
    import ccip_limiter_pkg::*;
#(
    parameter int NUM_VCS          = 4,
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int CL_LEN_W         = 2,
    parameter int CNT_W            = $clog2(MAX_ACTIVE_LINES + 1),
    parameter int VC_W             = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    ccip_vc_line_limiter_if.slave      in_req,
    ccip_vc_line_limiter_if.master     out_req,
    input  logic                       rsp_valid,
    input  logic [VC_W-1:0]            rsp_vc,
    output logic [NUM_VCS*CNT_W-1:0]   vc_active_lines,
    output logic [NUM_VCS-1:0]         vc_blocked,
    output logic                       underflow_err
`ifdef CCIP_VC_LINE_LIMITER_STATS_EN
    ,
    output logic [NUM_VCS*32-1:0]      vc_stall_cycles
`endif
);

    localparam int INC_W = CL_LEN_W + 1;

    logic [CNT_W-1:0]    vc_count [NUM_VCS];
    logic [NUM_VCS-1:0]  vc_inc, vc_dec, vc_uf;
    logic [INC_W-1:0]    req_lines;
    logic [CNT_W-1:0]    sel_count;
    logic                req_in_range, rsp_in_range, budget_ok;
    logic                out_free, in_ready, accept;

    logic                out_valid_d, out_valid_q;
    logic [VC_W-1:0]     out_vc_d, out_vc_q;
    logic [CL_LEN_W-1:0] out_len_d, out_len_q;
    logic                underflow_err_d, underflow_err_q;

    always_comb begin
        req_lines    = INC_W'(cl_len_to_lines(32'(in_req.cl_len)));
        req_in_range = int'(in_req.vc) < NUM_VCS;
        rsp_in_range = int'(rsp_vc) < NUM_VCS;
        sel_count    = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            if (int'(in_req.vc) == i) sel_count = vc_count[i];
        end
        // One spare bit so count + lines never wraps at the budget edge.
        budget_ok = ({1'b0, sel_count} + (CNT_W+1)'(req_lines))
                    <= (CNT_W+1)'(MAX_ACTIVE_LINES);
        out_free  = !out_valid_q || out_req.ready;
        in_ready  = out_free && req_in_range && budget_ok;
        accept    = in_req.valid && in_ready;

        out_valid_d = out_valid_q;
        out_vc_d    = out_vc_q;
        out_len_d   = out_len_q;
        if (out_free) begin
            out_valid_d = accept;
            if (accept) begin
                out_vc_d  = in_req.vc;
                out_len_d = in_req.cl_len;
            end
        end

        vc_inc = '0;
        vc_dec = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            vc_inc[i] = accept && (int'(in_req.vc) == i);
            vc_dec[i] = rsp_valid && (int'(rsp_vc) == i);
        end
    end

    assign underflow_err_d = underflow_err_q || (|vc_uf) || (rsp_valid && !rsp_in_range);

    // Lines are charged at accept, so a request parked in the output
    // register already counts against its VC.
    for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
        ccip_vc_line_counter #(
            .CNT_W           (CNT_W),
            .MAX_ACTIVE_LINES(MAX_ACTIVE_LINES),
            .INC_W           (INC_W)
        ) u_counter (
            .clk      (clk),
            .reset_n  (reset_n),
            .inc_en   (vc_inc[g]),
            .inc_lines(req_lines),
            .dec_en   (vc_dec[g]),
            .count    (vc_count[g]),
            .blocked  (vc_blocked[g]),
            .underflow(vc_uf[g])
        );
        assign vc_active_lines[g*CNT_W +: CNT_W] = vc_count[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q     <= 1'b0;
            out_vc_q        <= '0;
            out_len_q       <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_vc_q        <= out_vc_d;
            out_len_q       <= out_len_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign in_req.ready   = in_ready;
    assign out_req.valid  = out_valid_q;
    assign out_req.vc     = out_vc_q;
    assign out_req.cl_len = out_len_q;
    assign underflow_err  = underflow_err_q;

`ifdef CCIP_VC_LINE_LIMITER_STATS_EN
    logic [31:0] stall_d [NUM_VCS];
    logic [31:0] stall_q [NUM_VCS];

    // Only budget stalls count; a full output register is not charged.
    always_comb begin
        for (int i = 0; i < NUM_VCS; i++) begin
            stall_d[i] = stall_q[i];
            if (in_req.valid && req_in_range && !budget_ok && (int'(in_req.vc) == i)
                && (stall_q[i] != 32'hFFFF_FFFF)) begin
                stall_d[i] = stall_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VCS; i++) stall_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_VCS; i++) stall_q[i] <= stall_d[i];
        end
    end

    for (genvar s = 0; s < NUM_VCS; s++) begin : g_stall
        assign vc_stall_cycles[s*32 +: 32] = stall_q[s];
    end
`endif

endmodule

// File: doc/ccip_vc_line_limiter.md
Name: ccip_vc_line_limiter

Overview:
- Parametrised flow-control stage on the CCI-P c0 (read) request path, placed between AFU request logic and the platform shim.
- Tracks cache lines in flight per virtual channel and stalls new requests once a VC reaches its line budget.
- Generalises static per-VC bandwidth tuning values into runtime enforcement: configurable VC count, per-VC budgets, and a registered request output stage.

Parameters:
- NUM_VCS, 4, number of tracked VCs; request/response VC fields are clog2(NUM_VCS) wide (min 1).
- MAX_ACTIVE_LINES, 512, per-VC line budget; all VCs share one value.
- CL_LEN_W, 2, width of the request length field; the request covers cl_len+1 lines.
- CNT_W, clog2(MAX_ACTIVE_LINES+1), per-VC counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_req_valid  in  1  upstream request valid.
- in_req_ready  out  1  upstream may present the next request.
- in_req_vc  in  VC_W  request VC index.
- in_req_cl_len  in  CL_LEN_W  encoded length (0 = 1 line ... 3 = 4 lines).
- out_req_valid  out  1  registered request to shim.
- out_req_ready  in  1  shim accepts (inverse of almost-full).
- out_req_vc  out  VC_W  registered VC.
- out_req_cl_len  out  CL_LEN_W  registered length.
- rsp_valid  in  1  one read-response line returned.
- rsp_vc  in  VC_W  VC tag of the originating request (caller carries it in mdata).
- vc_active_lines  out  NUM_VCS*CNT_W  per-VC in-flight line count, packed with VC0 at the LSBs.
- vc_blocked  out  NUM_VCS  VC counter + 4 > MAX_ACTIVE_LINES (worst-case request would not fit).
- underflow_err  out  1  sticky; set when a response arrives on a VC whose count is 0.

Behaviour:
- Reset (async assert, sync deassert handled externally) clears the following: all counters 0; out_req_valid 0; out_req_vc/out_req_cl_len 0; underflow_err 0; vc_blocked 0; in_req_ready 1.
- Output register is one entry.
  - It is free when !out_req_valid or out_req_ready.
  - in_req_ready = free && (count[in_req_vc] + in_req_cl_len + 1 <= MAX_ACTIVE_LINES). This is combinational from in_req_vc, so the upstream must hold vc/len stable while valid.
- Accept = in_req_valid && in_req_ready. On accept, the register loads the request next cycle, and count[vc] increases by len+1 on the same edge.
- Latency is 1 cycle from accept to out_req_valid. The register holds its contents while out_req_valid && !out_req_ready.
- Lines are charged at accept, not at shim handoff. A request sitting in the register therefore already consumes budget.
- A response decrements count[rsp_vc] by 1.
- Accept and response on the same VC in the same cycle: count += (len+1) - 1, applied in one update with no lost event.
- Response on a VC with count 0: the count stays 0 and underflow_err is set until reset.
- Arithmetic is done at CNT_W+1 bits for the compare, so there is no wrap at budget edges.
- Out-of-range VC index (>= NUM_VCS, when NUM_VCS is not a power of 2):
  - request: treated as not ready;
  - response: ignored, and underflow_err is set.
- vc_blocked is registered from the post-update counts.

Optional Feature:
- Macro CCIP_VC_LINE_LIMITER_STATS_EN.
- When defined, adds output port vc_stall_cycles of width NUM_VCS*32.
  - It holds a per-VC saturating counter, incremented each cycle in_req_valid && !in_req_ready due to budget (not a downstream stall) for that VC.
  - Counters are cleared by reset and stick at 32'hFFFFFFFF.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package ccip_limiter_pkg:
  - typedef t_line_cnt (logic [CNT_W-1:0]);
  - function cl_len_to_lines();
  - localparam MAX_REQ_LINES = 4.
- One natural sub-module, ccip_vc_line_counter: a single VC counter with inc-by-n, dec-by-1, and an underflow flag. It is instantiated NUM_VCS times via generate.

Test Plan:
- Reset, then issue one 4-line request on VC1 with out_req_ready=1. Expect out_req_valid the next cycle and count[1]=4. Return 4 responses on VC1 and expect count[1]=0.
- MAX_ACTIVE_LINES=8: two 4-line requests on VC2. A third 1-line request holds in_req_ready=0 and vc_blocked[2]=1. One response later, the third request is accepted.
- Same-cycle accept of a 2-line request on VC0 and a response on VC0, starting from count 3: expect count 4.
- out_req_ready=0 for 5 cycles with a request registered: out_req_valid and its fields are held, in_req_ready=0, and the request releases the cycle ready returns.
- Response on VC3 with count 0: expect underflow_err=1 and count 0. Assert reset_n=0 mid-traffic: all outputs clear immediately (asynchronously).
- With STATS_EN: block VC2 for 10 cycles with in_req_valid held. Expect vc_stall_cycles[2]=10 and all other VCs 0.
